// File: rtl/pwm_peripheral.sv
// PWM output stage: 16 pins, each forced low, forced high, or driven by one shared 8-bit PWM.
// The duty cycle is shadowed and only takes effect at period boundaries, so mid-period writes cannot glitch a pin.
module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] prescaler;
   logic [7:0]    pwm_cnt;
   logic [7:0]    duty_q;
   logic          tick;
   logic          boundary;
   logic [7:0]    eff_duty;
   logic          level;
   logic [15:0]   en_out;
   logic [15:0]   en_pwm;

   assign tick     = (prescaler == PRE_LAST);
   assign boundary = (prescaler == '0) && (pwm_cnt == 8'd0);
   // The value written in the boundary cycle itself governs the whole new period.
   assign eff_duty = boundary ? pwm_duty_cycle : duty_q;
   assign level    = (eff_duty == 8'hFF) ? 1'b1 : (pwm_cnt < eff_duty);
   assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler    <= '0;
         pwm_cnt      <= 8'd0;
         duty_q       <= 8'd0;
         out          <= 16'h0000;
         period_start <= 1'b0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
         end
         if (boundary) begin
            duty_q <= pwm_duty_cycle;
         end
         out          <= en_out & (~en_pwm | {16{level}});
         period_start <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with CLK_DIV = 13 (period 3328 clocks).
module tb_pwm_peripheral;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] en_out_v;
   logic [15:0] en_pwm_v;
   logic [7:0]  duty;
   logic [15:0] out;
   logic        period_start;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pwm_peripheral #(.CLK_DIV(13)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_reg_out_7_0 (en_out_v[7:0]),
      .en_reg_out_15_8(en_out_v[15:8]),
      .en_reg_pwm_7_0 (en_pwm_v[7:0]),
      .en_reg_pwm_15_8(en_pwm_v[15:8]),
      .pwm_duty_cycle (duty),
      .out            (out),
      .period_start   (period_start)
   );

   typedef struct {
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [15:0] exp_ff;
      logic [15:0] exp_00;
   } sel_vec_t;

   typedef struct {
      logic [7:0] duty;
      int         hi;
   } duty_vec_t;

   sel_vec_t  sel_tab[5];
   duty_vec_t duty_tab[3];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ps();
      int n = 0;
      do begin
         step();
         n++;
      end while (!period_start && n < 5000);
      if (!period_start) chk("period_start_timeout", 0, 1);
   endtask

   // Called on a sample where period_start is high; returns on the next such sample.
   task automatic measure(input logic [15:0] mask, input logic [15:0] stat,
                          input int wr_at, input logic [7:0] wr_val,
                          output int hi, output int len, output int bad);
      int   changes = 0;
      logic prev = 1'b0;
      logic lvl;
      hi = 0; len = 0; bad = 0;
      do begin
         lvl = ((out & mask) == mask);
         if (lvl) hi++;
         else if ((out & mask) != 16'h0000) bad++;
         if ((out & ~mask) != stat) bad++;
         if (len > 0 && lvl != prev) changes++;
         prev = lvl;
         if (len == wr_at) duty = wr_val;
         len++;
         step();
      end while (!period_start && len < 5000);
      if (changes > 1) bad++;
   endtask

   initial begin
      int hi, len, bad;

      sel_tab[0] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
      sel_tab[1] = '{16'h0FF0, 16'hFFFF, 16'h0FF0, 16'h0000};
      sel_tab[2] = '{16'hA5A5, 16'h00FF, 16'hA5A5, 16'hA500};
      sel_tab[3] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
      sel_tab[4] = '{16'h1234, 16'h0F0F, 16'h1234, 16'h1030};

      duty_tab[0] = '{8'h00, 0};
      duty_tab[1] = '{8'hFF, 3328};
      duty_tab[2] = '{8'h01, 13};

      // Reset
      rst_n = 1'b0; en_out_v = 16'hFFFF; en_pwm_v = 16'hFFFF; duty = 8'h80;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("reset_out", out, 16'h0000);
         chk("reset_ps", period_start, 0);
      end
      rst_n = 1'b1;
      step();
      chk("release_ps", period_start, 1);
      chk("release_out", out, 16'hFFFF);
      step();
      chk("release_ps_single", period_start, 0);

      // Static drive, mid-period enable changes
      en_out_v = 16'h0FF0; en_pwm_v = 16'h0000;
      step();
      chk("static_0ff0", out, 16'h0FF0);
      en_out_v = 16'hF00F;
      step();
      chk("static_f00f", out, 16'hF00F);

      // Pin select table under constant-high and constant-low duty
      duty = 8'hFF;
      wait_ps();
      for (int i = 0; i < 5; i++) begin
         en_out_v = sel_tab[i].en_out; en_pwm_v = sel_tab[i].en_pwm;
         step();
         chk($sformatf("sel_ff_%0d", i), out, sel_tab[i].exp_ff);
      end
      duty = 8'h00;
      wait_ps();
      for (int i = 0; i < 5; i++) begin
         en_out_v = sel_tab[i].en_out; en_pwm_v = sel_tab[i].en_pwm;
         step();
         chk($sformatf("sel_00_%0d", i), out, sel_tab[i].exp_00);
      end

      // 50% duty
      en_out_v = 16'hFFFF; en_pwm_v = 16'hFFFF; duty = 8'h80;
      wait_ps();
      measure(16'hFFFF, 16'h0000, -1, 8'h00, hi, len, bad);
      chk("d80_high", hi, 1664);
      chk("d80_period", len, 3328);
      chk("d80_bad", bad, 0);

      // Extremes, two periods each
      for (int i = 0; i < 3; i++) begin
         duty = duty_tab[i].duty;
         wait_ps();
         for (int p = 0; p < 2; p++) begin
            measure(16'hFFFF, 16'h0000, -1, 8'h00, hi, len, bad);
            chk($sformatf("ext_%0h_high_p%0d", duty_tab[i].duty, p), hi, duty_tab[i].hi);
            chk($sformatf("ext_%0h_period_p%0d", duty_tab[i].duty, p), len, 3328);
            chk($sformatf("ext_%0h_bad_p%0d", duty_tab[i].duty, p), bad, 0);
         end
      end

      // Mid-period duty change is deferred to the next boundary
      duty = 8'h40;
      wait_ps();
      measure(16'hFFFF, 16'h0000, 500, 8'hC0, hi, len, bad);
      chk("mid_cur_high", hi, 832);
      chk("mid_cur_bad", bad, 0);
      measure(16'hFFFF, 16'h0000, -1, 8'h00, hi, len, bad);
      chk("mid_next_high", hi, 2496);
      chk("mid_next_period", len, 3328);
      chk("mid_next_bad", bad, 0);

      // Mixed pins, then a one-clock reset mid-period
      en_out_v = 16'h0F0F; en_pwm_v = 16'h00FF; duty = 8'h40;
      wait_ps();
      measure(16'h000F, 16'h0F00, -1, 8'h00, hi, len, bad);
      chk("mix_high", hi, 832);
      chk("mix_period", len, 3328);
      chk("mix_bad", bad, 0);
      for (int i = 0; i < 1000; i++) step();
      rst_n = 1'b0;
      step();
      chk("midrst_out", out, 16'h0000);
      chk("midrst_ps", period_start, 0);
      rst_n = 1'b1;
      step();
      chk("midrst_restart_ps", period_start, 1);
      chk("midrst_restart_out", out, 16'h0F0F);
      measure(16'h000F, 16'h0F00, -1, 8'h00, hi, len, bad);
      chk("midrst_high", hi, 832);
      chk("midrst_period", len, 3328);
      chk("midrst_bad", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration bytes written by the SPI register-write stage and drives the 16 user output pins. Each pin is forced low, forced high, or driven by a shared 8-bit PWM waveform, selected per pin by the enable registers. The duty cycle is shadowed and updated only at PWM period boundaries, so mid-period SPI writes cannot glitch the output.

Parameters:
CLK_DIV, 13, clock cycles per PWM step. Must be >= 1. Period = 256*CLK_DIV clocks, about 3.0 kHz at 10 MHz.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en_reg_out_7_0  input  8  output enable, pins 7..0
en_reg_out_15_8  input  8  output enable, pins 15..8
en_reg_pwm_7_0  input  8  PWM select, pins 7..0
en_reg_pwm_15_8  input  8  PWM select, pins 15..8
pwm_duty_cycle  input  8  requested duty cycle, 0x00..0xFF
out  output  16  registered pin drive
period_start  output  1  one-clock pulse marking the start of each PWM period

Behaviour:
- Single clock domain. All inputs are quasi-static register values from the SPI stage; no synchronisers are in this block.
- Reset: while rst_n is low at a rising edge:
  - prescaler, pwm_cnt and duty_q load 0.
  - out loads 16'h0000 and period_start loads 0.
  - A reset asserted mid-period aborts the period; counting restarts from 0 on the first edge with rst_n high.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler == CLK_DIV-1).
  - Width is clog2(CLK_DIV), minimum 1 bit.
  - With CLK_DIV = 1, tick is high every cycle.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps from 255 to 0.
- Boundary:
  - boundary = (prescaler == 0 && pwm_cnt == 0). This includes the first cycle after reset release.
  - On a boundary, duty_q <= pwm_duty_cycle.
  - eff_duty = boundary ? pwm_duty_cycle : duty_q.
- PWM level:
  - eff_duty == 8'hFF: level = 1 (constant high, no low step).
  - Otherwise: level = (pwm_cnt < eff_duty).
  - Duty 0 gives constant low.
  - Duty D in 1..254 gives D*CLK_DIV high clocks followed by (256-D)*CLK_DIV low clocks.
- Per-pin select, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - out[i] <= en_out[i] ? (en_pwm[i] ? level : 1) : 0
  - en_pwm is ignored when en_out[i] = 0.
- Latency:
  - out and period_start are registered, with one clock of latency from the counter state and inputs.
  - Enable-register changes reach out on the next edge, without waiting for a boundary.
  - Duty changes wait for the next boundary.
- period_start <= boundary. It is high for exactly one clock per period, aligned with the first out value of that period.
- Arithmetic: all comparisons are unsigned. There are no other wrap conditions.
- Simultaneous duty write and boundary: the new value is used for the whole new period.

Test Plan:
1. Reset check (CLK_DIV = 13): all enable bytes 0xFF, duty 0x80, rst_n low 5 clocks.
   - During reset: out = 0, period_start = 0.
   - First edge after release: period_start = 1 for one clock, out = 16'hFFFF.
2. Static drive: en_out = 16'h0FF0, en_pwm = 0, duty 0x80 -> out = 16'h0FF0 one clock after the inputs settle. Change en_out to 16'hF00F -> out = 16'hF00F on the next edge, mid-period.
3. 50% duty: duty 0x80, all enables 0xFFFF -> every out bit is high 1664 clocks then low 1664 clocks, period_start spacing is 3328 clocks, and all 16 bits are identical.
4. Extremes, each held for 2 full periods:
   - Duty 0x00 -> out stays 16'h0000.
   - Duty 0xFF -> out stays 16'hFFFF.
   - Duty 0x01 -> out is high exactly 13 clocks per period.
5. Mid-period duty change: start duty 0x40, write 0xC0 at 500 clocks into the period.
   - Current period: high 832 clocks.
   - Next period: high 2496 clocks.
   - No glitch at the write.
6. Mixed and reset mid-period: en_out = 16'h0F0F, en_pwm = 16'h00FF, duty 0x40.
   - Bits 3..0 carry PWM, bits 11..8 are static 1, all other bits are 0.
   - Pulse rst_n low for 1 clock at 1000 clocks into the period -> out = 0 on that edge, then a fresh period_start and a full period restart.
